axis_proc_arbiter: RTL and testbench
====================================

// Module: axis_proc_arbiter
// PURPOSE
//   Shares one AXI-Stream processor among NUM_SRC requesting streams.
//   - Round-robin grants source beats onto the processor input (p_axis_*).
//   - Records each granted source index in a tag FIFO.
//   - Returns in-order processor results (r_axis_*) on m_axis_* with tdest = originating source.
//   - Sits between host-side stream muxing and the axis_processor instance.
// PARAMETERS
//   NUM_SRC    4   number of requesting sources (>=2)
//   INP_WIDTH  8   source/processor input beat width, bits
//   OUT_WIDTH  8   processor result / m_axis beat width, bits
//   TAG_DEPTH  8   max beats in flight inside processor; power of 2, >=2
// PORTS
//   clk            in   1                   clock
//   arstn          in   1                   reset, synchronous, active-low
//   s_axis_tdata   in   NUM_SRC*INP_WIDTH   source i data at [i*INP_WIDTH +: INP_WIDTH]
//   s_axis_tvalid  in   NUM_SRC             per-source valid
//   s_axis_tready  out  NUM_SRC             per-source ready
//   p_axis_tdata   out  INP_WIDTH           to processor input
//   p_axis_tvalid  out  1                   to processor input
//   p_axis_tready  in   1                   from processor input
//   r_axis_tdata   in   OUT_WIDTH           from processor output
//   r_axis_tvalid  in   1                   from processor output
//   r_axis_tready  out  1                   to processor output
//   m_axis_tdata   out  OUT_WIDTH           routed result
//   m_axis_tdest   out  $clog2(NUM_SRC)     source index of result
//   m_axis_tvalid  out  1                   routed result valid
//   m_axis_tready  in   1                   routed result ready
//   inflight       out  $clog2(TAG_DEPTH+1) tags held in FIFO
//   err_orphan     out  1                   sticky: result with no matching tag
// BEHAVIOUR
//   Reset (arstn=0 at posedge):
//     - FSM=IDLE, rr_ptr=0, gnt=0, FIFO pointers/count=0, err_orphan=0.
//     - Result: p_axis_tvalid=0, s_axis_tready=0, m_axis_tvalid=0.
//     - Reset mid-operation discards all tags; later results are orphans.
//   Arbitration FSM:
//     - pick = first i with s_axis_tvalid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//     - IDLE: p_axis_tvalid=0, s_axis_tready=0.
//       If any valid and inflight<TAG_DEPTH: gnt<=pick, go to SEND (1-cycle grant latency).
//     - SEND: p_axis_tvalid=1, p_axis_tdata=source[gnt], s_axis_tready[gnt]=p_axis_tready, others 0.
//     - Grant locked: gnt and p_axis_tdata stay stable until p handshake,
//       regardless of other sources' valids (AXIS valid/data stability).
//     - On p handshake: push gnt to tag FIFO; rr_ptr<=(gnt+1) mod NUM_SRC.
//       Re-pick in the same cycle, scanning from gnt+1 with current valids.
//       If a pick exists and next-cycle count<TAG_DEPTH: stay SEND with gnt<=pick
//       (full throughput, 1 beat/cycle). Otherwise go to IDLE.
//   Result routing (combinational, 0 latency):
//     - avail = (count>0) || p_axis_tvalid.
//     - m_axis_tdata=r_axis_tdata; m_axis_tvalid=r_axis_tvalid && avail.
//     - r_axis_tready = avail ? m_axis_tready : 1.
//     - m_axis_tdest = count>0 ? FIFO head : gnt (bypass for zero-latency processors).
//     - Pop on m handshake when count>0.
//     - m handshake with count==0 in the same cycle as a p handshake:
//       push and pop cancel, nothing written.
//     - m handshake with count==0 and no p handshake: err_orphan<=1.
//     - r_axis_tvalid && !avail: beat consumed and dropped, err_orphan<=1.
//     - err_orphan is cleared only by reset.
//   FIFO and counters:
//     - Simultaneous push+pop with count>0: both pointers advance, count unchanged.
//     - Pointers wrap mod TAG_DEPTH. Push never occurs at count==TAG_DEPTH (FSM guard).
//     - inflight = count (registered).
//   No combinational path from any *_tready to any *_tvalid except r_axis_tready.
// TESTING
//   - Passthrough processor, only src2 sends 0xA5 -> after 1-cycle grant,
//     m_axis 0xA5, tdest=2, same cycle as p handshake; inflight stays 0.
//   - All 4 sources valid continuously, all readies 1 -> p grants 0,1,2,3,0,1...
//     one beat per cycle; each m_axis_tdest matches its source.
//   - Grant src1, hold p_axis_tready=0 for 4 cycles, raise s_axis_tvalid[0] -> gnt stays 1;
//     p_axis_tdata stable; s_axis_tready[0]=0 throughout.
//   - Model processor = 16-deep FIFO, m_axis_tready=0 -> exactly 8 p handshakes,
//     then p_axis_tvalid=0, inflight=8; one m pop -> one new grant.
//   - r_axis_tvalid=1, data 0x3C, inflight=0, all sources idle -> m_axis_tvalid=0,
//     r_axis_tready=1, err_orphan=1 next cycle, stays 1 until reset.
//   - inflight=5, arstn low 1 cycle -> inflight=0, FSM IDLE, rr_ptr=0, err_orphan=0;
//     stale results then set err_orphan.

Source files
------------

// File: rtl/axis_proc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_proc_arbiter
// Description : Round-robin arbiter sharing one AXI-Stream processor among
//               NUM_SRC sources. Granted source indices are queued in a tag
//               FIFO so in-order processor results can be routed back with
//               tdest set to the originating source.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_proc_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int INP_WIDTH = 8,
    parameter int OUT_WIDTH = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic [NUM_SRC*INP_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic [INP_WIDTH-1:0]           p_axis_tdata,
    output logic                           p_axis_tvalid,
    input  logic                           p_axis_tready,
    input  logic [OUT_WIDTH-1:0]           r_axis_tdata,
    input  logic                           r_axis_tvalid,
    output logic                           r_axis_tready,
    output logic [OUT_WIDTH-1:0]           m_axis_tdata,
    output logic [$clog2(NUM_SRC)-1:0]     m_axis_tdest,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
    output logic                           err_orphan
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   gnt, gnt_nxt, gnt_inc;
    logic [SW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SW-1:0]   scan_start, pick;
    logic            pick_found;
    int              scan_idx;

    logic [SW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;

    logic            p_hs, m_hs, avail, push, pop, orphan;

    // Source after the current grant, and where the round-robin scan begins:
    // while sending we re-pick from the source after the beat just granted.
    always_comb begin
        gnt_inc    = (gnt == SW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
        scan_start = (state == S_SEND) ? gnt_inc : rr_ptr;
    end

    // Round-robin scan: first valid source at or after scan_start.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = int'(scan_start) + k;
            if (scan_idx >= NUM_SRC) scan_idx = scan_idx - NUM_SRC;
            if (!pick_found && s_axis_tvalid[SW'(scan_idx)]) begin
                pick       = SW'(scan_idx);
                pick_found = 1'b1;
            end
        end
    end

    // Datapath muxing, result routing and tag FIFO push/pop decisions.
    always_comb begin
        p_axis_tvalid = (state == S_SEND);
        p_axis_tdata  = s_axis_tdata[gnt*INP_WIDTH +: INP_WIDTH];
        s_axis_tready = '0;
        if (state == S_SEND) s_axis_tready[gnt] = p_axis_tready;

        // A result is expected if a tag is queued or a beat is being offered
        // right now (zero-latency processor bypass).
        avail         = (count != '0) || p_axis_tvalid;
        m_axis_tdata  = r_axis_tdata;
        m_axis_tvalid = r_axis_tvalid && avail;
        r_axis_tready = avail ? m_axis_tready : 1'b1;
        m_axis_tdest  = (count != '0) ? tag_mem[rd_ptr] : gnt;

        p_hs   = p_axis_tvalid && p_axis_tready;
        m_hs   = m_axis_tvalid && m_axis_tready;
        // Bypassed result with an empty FIFO: push and pop cancel out.
        push   = p_hs && !(m_hs && (count == '0));
        pop    = m_hs && (count != '0);
        orphan = (m_hs && (count == '0) && !p_hs) || (r_axis_tvalid && !avail);

        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Arbitration next-state: grant is locked in SEND until the p handshake.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        case (state)
            S_IDLE: begin
                if (pick_found && (count < CW'(TAG_DEPTH))) begin
                    gnt_nxt   = pick;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (p_hs) begin
                    rr_ptr_nxt = gnt_inc;
                    if (pick_found && (count_nxt < CW'(TAG_DEPTH))) begin
                        gnt_nxt = pick;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state, FIFO pointers, occupancy and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state      <= S_IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            count  <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (orphan) err_orphan <= 1'b1;
        end
    end

    // Tag storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt;
    end

    assign inflight = count;

endmodule
`default_nettype wire

// File: tb/tb_axis_proc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_proc_arbiter
// Description : Self-checking bench for axis_proc_arbiter with a processor
//               model (passthrough / 16-deep FIFO / manual) and a scoreboard
//               of expected routed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_proc_arbiter;

    localparam int NS = 4;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int TD = 8;

    localparam int PASS  = 0;
    localparam int PFIFO = 1;
    localparam int MAN   = 2;

    typedef struct packed {
        logic [1:0] dest;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic [IW-1:0]   src_data [NS];
    logic [NS-1:0]   src_valid = '0;
    logic [NS*IW-1:0] s_axis_tdata;
    logic [NS-1:0]   s_axis_tready;
    logic [IW-1:0]   p_axis_tdata;
    logic            p_axis_tvalid, p_axis_tready;
    logic [OW-1:0]   r_axis_tdata;
    logic            r_axis_tvalid, r_axis_tready;
    logic [OW-1:0]   m_axis_tdata;
    logic [1:0]      m_axis_tdest;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [3:0]      inflight;
    logic            err_orphan;

    int              proc_mode = PASS;
    logic            man_p_ready = 1'b0;
    logic            man_r_valid = 1'b0;
    logic [OW-1:0]   man_r_data = '0;
    logic [OW-1:0]   pmem [16];
    logic [3:0]      pwp, prp;
    logic [4:0]      pcnt;

    exp_t            exp_q [$];
    int              gnt_log [$];
    exp_t            mon_ne, mon_e;
    int              p_hs_cnt = 0;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NS; i++) s_axis_tdata[i*IW +: IW] = src_data[i];
    end

    assign p_axis_tready = (proc_mode == PASS)  ? r_axis_tready :
                           (proc_mode == PFIFO) ? (pcnt < 5'd16) : man_p_ready;
    assign r_axis_tvalid = (proc_mode == PASS)  ? p_axis_tvalid :
                           (proc_mode == PFIFO) ? (pcnt != 5'd0) : man_r_valid;
    assign r_axis_tdata  = (proc_mode == PASS)  ? p_axis_tdata :
                           (proc_mode == PFIFO) ? pmem[prp] : man_r_data;

    axis_proc_arbiter #(
        .NUM_SRC  (NS),
        .INP_WIDTH(IW),
        .OUT_WIDTH(OW),
        .TAG_DEPTH(TD)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(src_valid),
        .s_axis_tready(s_axis_tready),
        .p_axis_tdata (p_axis_tdata),
        .p_axis_tvalid(p_axis_tvalid),
        .p_axis_tready(p_axis_tready),
        .r_axis_tdata (r_axis_tdata),
        .r_axis_tvalid(r_axis_tvalid),
        .r_axis_tready(r_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tdest (m_axis_tdest),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .inflight     (inflight),
        .err_orphan   (err_orphan)
    );

    // Processor model in FIFO mode: 16 deep, result = inverted input.
    always @(posedge clk) begin
        if (!arstn) begin
            pwp  <= '0;
            prp  <= '0;
            pcnt <= '0;
        end else if (proc_mode == PFIFO) begin
            if (p_axis_tvalid && p_axis_tready) begin
                pmem[pwp] <= ~p_axis_tdata;
                pwp       <= pwp + 1'b1;
            end
            if (r_axis_tvalid && r_axis_tready) prp <= prp + 1'b1;
            pcnt <= pcnt + 5'(p_axis_tvalid && p_axis_tready)
                         - 5'(r_axis_tvalid && r_axis_tready);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each p handshake predicts one routed result from the
    // granted source's own data; each m handshake consumes one prediction.
    always @(negedge clk) begin
        if (!arstn) begin
            exp_q.delete();
        end else begin
            if (p_axis_tvalid && p_axis_tready) begin
                p_hs_cnt++;
                chk("p_ready_onehot", 32'($countones(s_axis_tready)), 1);
                for (int i = 0; i < NS; i++) begin
                    if (s_axis_tready[i]) begin
                        chk("p_data_route", p_axis_tdata, src_data[i]);
                        mon_ne.dest = 2'(i);
                        mon_ne.data = (proc_mode == PFIFO) ? ~src_data[i] : src_data[i];
                        exp_q.push_back(mon_ne);
                        gnt_log.push_back(i);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("m_tdest", m_axis_tdest, mon_e.dest);
                    chk("m_tdata", m_axis_tdata, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
    endtask

    // One clock of free-running sources: each accepted beat advances its data.
    task automatic step();
        logic [NS-1:0] hs;
        @(negedge clk);
        hs = src_valid & s_axis_tready;
        tick();
        for (int i = 0; i < NS; i++) if (hs[i]) src_data[i] = src_data[i] + 8'd1;
    endtask

    initial begin
        int lat, got, base, gbase, k;
        for (int i = 0; i < NS; i++) src_data[i] = '0;

        // ---- reset state and single-source passthrough ----
        proc_mode = PASS; m_axis_tready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_p_valid", p_axis_tvalid, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_orphan", err_orphan, 0);
        tick();
        src_data[2] = 8'hA5; src_valid = 4'b0100;
        lat = 0; got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (s_axis_tready[2]) begin
                got = 1;
                chk("t1_m_valid", m_axis_tvalid, 1);
                chk("t1_m_data", m_axis_tdata, 8'hA5);
                chk("t1_m_tdest", m_axis_tdest, 2);
                chk("t1_inflight_hs", inflight, 0);
            end else lat++;
        end
        chk("t1_handshake_seen", got, 1);
        chk("t1_grant_latency", lat, 1);
        tick();
        src_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("t1_inflight_end", inflight, 0);

        // ---- all sources valid: rotating grants, one beat per cycle ----
        do_reset();
        for (int i = 0; i < NS; i++) src_data[i] = 8'(8'h10 * i);
        src_valid = 4'hF;
        base = p_hs_cnt; gbase = gnt_log.size();
        repeat (13) step();
        chk("t2_beats", p_hs_cnt - base, 12);
        for (int j = 0; j < 8; j++) chk("t2_rr_order", gnt_log[gbase + j], j % 4);
        src_valid = '0;
        repeat (4) tick();
        @(negedge clk);
        chk("t2_inflight_end", inflight, 0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // ---- grant lock while the processor stalls ----
        proc_mode = MAN; man_p_ready = 1'b0; man_r_valid = 1'b0;
        do_reset();
        src_data[1] = 8'h77; src_data[0] = 8'h11; src_valid = 4'b0010;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge clk);
            if (p_axis_tvalid) got = 1;
        end
        chk("t3_grant_seen", got, 1);
        tick();
        src_valid = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3_lock_data", p_axis_tdata, 8'h77);
            chk("t3_lock_ready", s_axis_tready, 0);
            tick();
        end
        man_p_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", s_axis_tready, 4'b0010);
        tick();
        src_valid = 4'b0001; man_p_ready = 1'b0;
        @(negedge clk);
        chk("t3_next_grant", p_axis_tdata, 8'h11);
        chk("t3_inflight", inflight, 1);
        tick();
        src_valid = '0;

        // ---- tag FIFO full with a blocked result sink ----
        proc_mode = PFIFO; m_axis_tready = 1'b0;
        do_reset();
        for (int i = 0; i < NS; i++) src_data[i] = 8'(8'h40 + 8'h10 * i);
        src_valid = 4'hF;
        base = p_hs_cnt;
        repeat (16) step();
        chk("t4_fill_beats", p_hs_cnt - base, 8);
        @(negedge clk);
        chk("t4_full_p_valid", p_axis_tvalid, 0);
        chk("t4_full_inflight", inflight, 8);
        tick();
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("t4_pop_m_valid", m_axis_tvalid, 1);
        tick();
        m_axis_tready = 1'b0;
        base = p_hs_cnt;
        repeat (6) step();
        chk("t4_refill_beats", p_hs_cnt - base, 1);
        chk("t4_refill_inflight", inflight, 8);
        src_valid = '0; m_axis_tready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        chk("t4_drain_inflight", inflight, 0);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_no_orphan", err_orphan, 0);

        // ---- orphan result with nothing in flight ----
        proc_mode = MAN; man_p_ready = 1'b0;
        do_reset();
        man_r_valid = 1'b1; man_r_data = 8'h3C;
        @(negedge clk);
        chk("t5_m_valid", m_axis_tvalid, 0);
        chk("t5_r_ready", r_axis_tready, 1);
        chk("t5_orphan_pre", err_orphan, 0);
        tick();
        man_r_valid = 1'b0;
        @(negedge clk);
        chk("t5_orphan_set", err_orphan, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("t5_orphan_sticky", err_orphan, 1);

        // ---- reset with five beats in flight ----
        do_reset();
        man_p_ready = 1'b1; m_axis_tready = 1'b0; src_valid = 4'b0001;
        src_data[0] = 8'h20;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            @(negedge clk);
            if (p_axis_tvalid && p_axis_tready) k++;
        end
        chk("t6_beats", k, 5);
        tick();
        man_p_ready = 1'b0; src_valid = '0;
        @(negedge clk);
        chk("t6_inflight_pre", inflight, 5);
        do_reset();
        @(negedge clk);
        chk("t6_inflight_rst", inflight, 0);
        chk("t6_p_valid_rst", p_axis_tvalid, 0);
        chk("t6_orphan_rst", err_orphan, 0);
        tick();
        man_r_valid = 1'b1; man_r_data = 8'h5A;
        @(negedge clk);
        chk("t6_stale_m_valid", m_axis_tvalid, 0);
        tick();
        man_r_valid = 1'b0;
        @(negedge clk);
        chk("t6_stale_orphan", err_orphan, 1);
        tick();
        src_data[0] = 8'hC0; src_data[3] = 8'hF3; src_valid = 4'b1001;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge clk);
            if (p_axis_tvalid) begin
                got = 1;
                chk("t6_rr_reset_pick", p_axis_tdata, 8'hC0);
            end
        end
        chk("t6_grant_seen", got, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
